irq_prio_ctrl: RTL and testbench
================================

Name: irq_prio_ctrl

Overview:
- Prioritised interrupt controller that sits directly upstream of the cdm16 core.
- Collects up to N_SOURCES peripheral request lines and drives the core's in_irq and int_vec inputs.
- Consumes the core's IAck.
- Tracks in-service sources until software issues EOI through four memory-mapped registers on the core's data bus.

Parameters:
- N_SOURCES, 8, number of request lines (1..8); index 0 is highest priority.
- VEC_BASE, 16, vector of source 0; source i gets VEC_BASE+i; VEC_BASE+N_SOURCES-1 must be ≤ 63.
- BASE_ADDR, 16'hFF00, byte address of register 0; must be 8-byte aligned.

Ports:
- clk  in  1  core clock (the core's gated clk output).
- rst_n  in  1  asynchronous active-low reset.
- src  in  N_SOURCES  request lines, synchronous to clk.
- address  in  16  core bus address.
- mem  in  1  core bus memory-cycle strobe.
- data  in  1  core bus data (not instruction) cycle.
- read  in  1  core bus read (1) / write (0).
- word  in  1  core bus word access; ignored, only bits [7:0] are meaningful.
- wdata  in  16  core data_out.
- rdata  out  16  read data for the bus mux.
- sel  out  1  address hit for the bus mux.
- irq  out  1  to core in_irq.
- int_vec  out  6  to core int_vec.
- iack  in  1  from core IAck.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - All state updates on the falling edge of clk, the same edge the core samples on.
- Registers (offsets from BASE_ADDR), each N_SOURCES bits wide, zero-extended to 16 on read:
  - 0 ENABLE (RW)
  - 2 PENDING (R; write-1-to-clear)
  - 4 MODE (RW; 1 = edge, 0 = level)
  - 6 INSERV (R; any write = EOI)
- Reset: ENABLE, PENDING, MODE, INSERV and src_prev all 0. Resulting outputs: irq=0, int_vec=0, rdata=0.
- Decode:
  - sel = mem & data & (address[15:3] == BASE_ADDR[15:3]); address[0] is ignored.
  - Write strobe = sel & !read.
  - rdata is combinational and shows the selected register when sel & read, else 0.
- Pending, edge-mode source i:
  - Sets when src[i] & !src_prev[i].
  - Clears on a W1C write bit or on iack while i is presented.
  - A new edge in the same cycle as a clear wins: the bit stays set.
- Pending, level-mode source i:
  - PENDING[i] = src[i], registered each cycle.
  - W1C and iack have no effect on it.
- src_prev <= src every cycle.
- Eligible(i) = PENDING[i] & ENABLE[i] & (i < lowest set index of INSERV, or INSERV == 0).
- Presented index p = lowest eligible i.
  - irq = any eligible; combinational from registered state.
  - int_vec = VEC_BASE + p when irq, else 0.
- iack:
  - Sampled on the falling edge. If irq=1: INSERV[p] <= 1, and pending is cleared per the rules above.
  - If irq=0, iack is ignored.
  - iack held high for several cycles acts once per cycle, using the then-current p.
- EOI:
  - Clears the lowest set INSERV bit, computed from pre-edge state.
  - EOI with INSERV == 0 is a no-op.
  - Simultaneous EOI and iack: the clear is applied first, then INSERV[p] is set. p is computed from pre-edge state and may equal the bit being cleared; that bit ends up set.
- Nesting: a higher-priority source pre-empts an in-service lower one; equal or lower priority is blocked until EOI.
- Clearing ENABLE[i] drops irq the next cycle; PENDING[i] is retained.
- Writes to ENABLE/MODE take effect from the next cycle. A MODE change from level to edge keeps the current PENDING value.
- Reset asserted mid-sequence clears everything immediately and asynchronously; irq drops without waiting for a clock edge.

Test Plan:
- Reset then idle: rst_n=0 → irq=0, int_vec=0; rdata of every register reads 0.
- Basic edge path:
  - Stimulus: ENABLE=0x05, MODE=0x05, src[2] pulses one cycle.
  - Response: PENDING=0x04, irq=1, int_vec=18.
  - iack → irq=0, INSERV=0x04, PENDING=0.
- Priority and nesting:
  - Stimulus: src[2] taken (INSERV=0x04), then src[0] and src[5] edges, ENABLE=0x25|0x01.
  - Response: int_vec=16; iack → INSERV=0x05, irq=0 (source 5 blocked).
  - EOI clears bit 0 → still blocked; second EOI → irq=1, int_vec=21.
- Level mode:
  - Stimulus: MODE=0, src[3] high.
  - Response: W1C 0x08 has no effect; iack sets INSERV=0x08 and PENDING stays 0x08.
  - Drop src[3] → PENDING=0 next cycle.
- Simultaneous events:
  - Edge on src[1] in the same cycle as W1C 0x02 → PENDING[1] stays 1.
  - EOI together with iack → the old lowest INSERV bit clears and the new p bit is set.
- Bus decode and reset mid-operation:
  - Stimulus: byte write at BASE_ADDR+1, then read BASE_ADDR+4 with mem=0.
  - Response: the write updates ENABLE; the read gives sel=0, rdata=0.
  - rst_n low while irq=1 → irq falls asynchronously.

Source files
------------

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: prioritised interrupt controller in front of the cdm16 core.
// Collects up to N_SOURCES request lines and drives in_irq/int_vec. Tracks
// in-service sources until software signals end-of-interrupt through four
// byte-wide memory-mapped registers.
//
// Register map (offsets from BASE_ADDR, address[0] ignored):
//   0 ENABLE  RW
//   2 PENDING R, write-1-to-clear (edge-mode bits only)
//   4 MODE    RW, 1 = edge, 0 = level
//   6 INSERV  R, any write = EOI (clears the lowest set bit)
//
// All state moves on the falling clock edge, the same edge the core samples.
//
// Interrupt handshake: irq/int_vec form a level request that is purely
// combinational from registered state. The core acknowledges by raising iack,
// which is sampled on the falling edge. An iack seen while irq=1 moves the
// presented source into service (INSERV[p] set, edge-mode PENDING[p] cleared).
// An iack seen while irq=0 is dropped. A held iack acts once per cycle, each
// time against whatever source is presented in that cycle.
//
// Legal parameter range: 1 <= N_SOURCES <= 8, VEC_BASE + N_SOURCES - 1 <= 63,
// BASE_ADDR 8-byte aligned.

module irq_prio_ctrl #(
    parameter int          N_SOURCES = 8,
    parameter int          VEC_BASE  = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SOURCES-1:0] src,
    input  logic [15:0]          address,
    input  logic                 mem,
    input  logic                 data,
    input  logic                 read,
    input  logic                 word,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata,
    output logic                 sel,
    output logic                 irq,
    output logic [5:0]           int_vec,
    input  logic                 iack
);

    localparam int         N         = N_SOURCES;
    localparam logic [5:0] VEC_BASE6 = 6'(VEC_BASE);

    // Register indices as selected by address[2:1].
    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_INSERV  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N-1:0] enable_q;
    logic [N-1:0] pending_q;
    logic [N-1:0] mode_q;
    logic [N-1:0] inserv_q;
    logic [N-1:0] src_prev_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0]   reg_idx;
    logic         wr_stb;
    logic         wr_enable;
    logic         wr_pending;
    logic         wr_mode;
    logic         eoi;
    logic [N-1:0] wbits;

    // The bus is byte-oriented for this block: word and the upper data byte
    // carry nothing, and address[0] does not distinguish registers.
    logic unused_bus;
    assign unused_bus = ^{word, address[0], wdata};

    assign sel        = mem & data & (address[15:3] == BASE_ADDR[15:3]);
    assign reg_idx    = address[2:1];
    assign wr_stb     = sel & ~read;
    assign wr_enable  = wr_stb & (reg_idx == REG_ENABLE);
    assign wr_pending = wr_stb & (reg_idx == REG_PENDING);
    assign wr_mode    = wr_stb & (reg_idx == REG_MODE);
    assign eoi        = wr_stb & (reg_idx == REG_INSERV);
    assign wbits      = wdata[N-1:0];

    // Read mux: shows the selected register only during a read hit.
    always_comb begin
        rdata = 16'h0000;
        if (sel && read) begin
            case (reg_idx)
                REG_ENABLE:  rdata = 16'(enable_q);
                REG_PENDING: rdata = 16'(pending_q);
                REG_MODE:    rdata = 16'(mode_q);
                REG_INSERV:  rdata = 16'(inserv_q);
                default:     rdata = 16'h0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Priority resolution
    // ------------------------------------------------------------------
    logic [N-1:0] allowed;      // strictly higher priority than any in-service
    logic [N-1:0] eligible;
    logic [2:0]   present_idx;  // p, lowest eligible index
    logic [N-1:0] present_oh;
    logic [N-1:0] inserv_low_oh;
    logic         take;

    // A source may interrupt only if no source of equal or higher priority
    // (lower or equal index) is currently in service.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        allowed = '0;
        for (int i = 0; i < N; i++) begin
            seen       = seen | inserv_q[i];
            allowed[i] = ~seen;
        end
    end

    assign eligible = pending_q & enable_q & allowed;
    assign irq      = |eligible;

    // Scanning from the top down leaves the lowest eligible index in p.
    always_comb begin
        present_idx = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                present_idx = 3'(i);
            end
        end
    end

    // One-hot of the presented source, empty when nothing is requested.
    always_comb begin
        present_oh = '0;
        for (int i = 0; i < N; i++) begin
            present_oh[i] = irq && (present_idx == 3'(i));
        end
    end

    // One-hot of the lowest in-service bit: the one an EOI retires.
    always_comb begin
        logic found;
        found         = 1'b0;
        inserv_low_oh = '0;
        for (int i = 0; i < N; i++) begin
            if (inserv_q[i] && !found) begin
                inserv_low_oh[i] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    assign int_vec = irq ? (VEC_BASE6 + 6'(present_idx)) : 6'd0;
    assign take    = iack & irq;

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    logic [N-1:0] edge_set;
    logic [N-1:0] edge_clr;
    logic [N-1:0] pending_edge_d;
    logic [N-1:0] pending_d;
    logic [N-1:0] inserv_d;

    // Edge-mode bits: a fresh rising edge beats any clear in the same cycle.
    // Level-mode bits simply follow the request line.
    always_comb begin
        edge_set       = src & ~src_prev_q;
        edge_clr       = (wr_pending ? wbits : '0) | (take ? present_oh : '0);
        pending_edge_d = (pending_q & ~edge_clr) | edge_set;
        pending_d      = (mode_q & pending_edge_d) | (~mode_q & src);
    end

    // EOI retires the old lowest in-service bit first; an acknowledge in the
    // same cycle then marks the presented source, so its bit ends up set.
    always_comb begin
        inserv_d = inserv_q;
        if (eoi) begin
            inserv_d = inserv_d & ~inserv_low_oh;
        end
        if (take) begin
            inserv_d = inserv_d | present_oh;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Software-owned configuration registers.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            mode_q   <= '0;
        end else begin
            if (wr_enable) begin
                enable_q <= wbits;
            end
            if (wr_mode) begin
                mode_q <= wbits;
            end
        end
    end

    // Request tracking: edge detector history, pending and in-service sets.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pending_q  <= '0;
            inserv_q   <= '0;
        end else begin
            src_prev_q <= src;
            pending_q  <= pending_d;
            inserv_q   <= inserv_d;
        end
    end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb_irq_prio_ctrl: directed, table-driven bench for irq_prio_ctrl.
// Inputs change after the rising edge; the DUT updates on the falling edge;
// outputs are sampled after the next rising edge, well away from it.

module tb_irq_prio_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int          NROWS = 34;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src;
    logic [15:0] address;
    logic        mem;
    logic        data;
    logic        read;
    logic        word;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        sel;
    logic        irq;
    logic [5:0]  int_vec;
    logic        iack;

    always #10 clk = ~clk;

    irq_prio_ctrl #(
        .N_SOURCES(8),
        .VEC_BASE (16),
        .BASE_ADDR(BASE)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .src    (src),
        .address(address),
        .mem    (mem),
        .data   (data),
        .read   (read),
        .word   (word),
        .wdata  (wdata),
        .rdata  (rdata),
        .sel    (sel),
        .irq    (irq),
        .int_vec(int_vec),
        .iack   (iack)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic bus_idle();
        mem     = 1'b0;
        data    = 1'b0;
        read    = 1'b1;
        address = 16'h0000;
        wdata   = 16'h0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [15:0] addr, output logic [15:0] v);
        address = addr;
        mem     = 1'b1;
        data    = 1'b1;
        read    = 1'b1;
        #1;
        v = rdata;
        bus_idle();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] val);
        address = addr;
        mem     = 1'b1;
        data    = 1'b1;
        read    = 1'b0;
        wdata   = val;
        tick();
        bus_idle();
    endtask

    // ------------------------------------------------------------------
    // Vector table: one cycle of inputs, then the state expected after it
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  src;
        logic        we;
        logic [2:0]  off;
        logic [15:0] wd;
        logic        iack;
        logic        exp_irq;
        logic [5:0]  exp_vec;
        logic [7:0]  exp_pend;
        logic [7:0]  exp_ins;
    } vec_t;

    vec_t tbl[NROWS];

    function automatic vec_t mk(input logic [7:0] s, input logic we, input logic [2:0] off,
                                input logic [15:0] wd, input logic ia, input logic ei,
                                input logic [5:0] ev, input logic [7:0] ep, input logic [7:0] es);
        vec_t v;
        v.src = s; v.we = we; v.off = off; v.wd = wd; v.iack = ia;
        v.exp_irq = ei; v.exp_vec = ev; v.exp_pend = ep; v.exp_ins = es;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        logic [15:0] v;

        //            src   we  off  wdata    iack  irq vec pend   inserv
        // basic edge path on source 2
        tbl[0]  = mk(8'h00, 1, 3'd0, 16'h0005, 0,   0,  0, 8'h00, 8'h00);
        tbl[1]  = mk(8'h00, 1, 3'd4, 16'h0005, 0,   0,  0, 8'h00, 8'h00);
        tbl[2]  = mk(8'h04, 0, 3'd0, 16'h0000, 0,   1, 18, 8'h04, 8'h00);
        tbl[3]  = mk(8'h00, 0, 3'd0, 16'h0000, 0,   1, 18, 8'h04, 8'h00);
        tbl[4]  = mk(8'h00, 0, 3'd0, 16'h0000, 1,   0,  0, 8'h00, 8'h04);
        // priority and nesting with sources 0 and 5
        tbl[5]  = mk(8'h00, 1, 3'd4, 16'h0025, 0,   0,  0, 8'h00, 8'h04);
        tbl[6]  = mk(8'h00, 1, 3'd0, 16'h0025, 0,   0,  0, 8'h00, 8'h04);
        tbl[7]  = mk(8'h21, 0, 3'd0, 16'h0000, 0,   1, 16, 8'h21, 8'h04);
        tbl[8]  = mk(8'h00, 0, 3'd0, 16'h0000, 1,   0,  0, 8'h20, 8'h05);
        tbl[9]  = mk(8'h00, 1, 3'd6, 16'h0000, 0,   0,  0, 8'h20, 8'h04);
        tbl[10] = mk(8'h00, 1, 3'd6, 16'h0000, 0,   1, 21, 8'h20, 8'h00);
        tbl[11] = mk(8'h00, 0, 3'd0, 16'h0000, 1,   0,  0, 8'h00, 8'h20);
        tbl[12] = mk(8'h00, 1, 3'd6, 16'h0000, 0,   0,  0, 8'h00, 8'h00);
        // level mode on source 3
        tbl[13] = mk(8'h00, 1, 3'd4, 16'h0000, 0,   0,  0, 8'h00, 8'h00);
        tbl[14] = mk(8'h00, 1, 3'd0, 16'h000A, 0,   0,  0, 8'h00, 8'h00);
        tbl[15] = mk(8'h08, 0, 3'd0, 16'h0000, 0,   1, 19, 8'h08, 8'h00);
        tbl[16] = mk(8'h08, 1, 3'd2, 16'h0008, 0,   1, 19, 8'h08, 8'h00);
        tbl[17] = mk(8'h08, 0, 3'd0, 16'h0000, 1,   0,  0, 8'h08, 8'h08);
        tbl[18] = mk(8'h00, 0, 3'd0, 16'h0000, 0,   0,  0, 8'h00, 8'h08);
        tbl[19] = mk(8'h00, 1, 3'd6, 16'h0000, 0,   0,  0, 8'h00, 8'h00);
        // edge vs W1C in the same cycle on source 1
        tbl[20] = mk(8'h00, 1, 3'd4, 16'h0002, 0,   0,  0, 8'h00, 8'h00);
        tbl[21] = mk(8'h02, 0, 3'd0, 16'h0000, 0,   1, 17, 8'h02, 8'h00);
        tbl[22] = mk(8'h00, 0, 3'd0, 16'h0000, 0,   1, 17, 8'h02, 8'h00);
        tbl[23] = mk(8'h02, 1, 3'd2, 16'h0002, 0,   1, 17, 8'h02, 8'h00);
        tbl[24] = mk(8'h00, 1, 3'd2, 16'h0002, 0,   0,  0, 8'h00, 8'h00);
        // EOI together with iack
        tbl[25] = mk(8'h08, 0, 3'd0, 16'h0000, 0,   1, 19, 8'h08, 8'h00);
        tbl[26] = mk(8'h00, 0, 3'd0, 16'h0000, 1,   0,  0, 8'h00, 8'h08);
        tbl[27] = mk(8'h02, 0, 3'd0, 16'h0000, 0,   1, 17, 8'h02, 8'h08);
        tbl[28] = mk(8'h00, 1, 3'd6, 16'h0000, 1,   0,  0, 8'h00, 8'h02);
        tbl[29] = mk(8'h00, 1, 3'd6, 16'h0000, 0,   0,  0, 8'h00, 8'h00);
        // iack with no request, then ENABLE removal keeps PENDING
        tbl[30] = mk(8'h00, 0, 3'd0, 16'h0000, 1,   0,  0, 8'h00, 8'h00);
        tbl[31] = mk(8'h02, 0, 3'd0, 16'h0000, 0,   1, 17, 8'h02, 8'h00);
        tbl[32] = mk(8'h00, 1, 3'd0, 16'h0008, 0,   0,  0, 8'h02, 8'h00);
        tbl[33] = mk(8'h00, 1, 3'd2, 16'h0002, 0,   0,  0, 8'h00, 8'h00);

        // ---------------- reset then idle ----------------
        rst_n = 1'b0;
        src   = 8'h00;
        iack  = 1'b0;
        word  = 1'b0;
        bus_idle();
        #1;
        chk("reset_irq", 16'(irq), 16'h0000);
        chk("reset_vec", 16'(int_vec), 16'h0000);
        chk("reset_sel_idle", 16'(sel), 16'h0000);
        for (int k = 0; k < 4; k++) begin
            read_reg(BASE + 16'(2 * k), v);
            chk($sformatf("reset_reg%0d", 2 * k), v, 16'h0000);
        end
        tick();
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int r = 0; r < NROWS; r++) begin
            src  = tbl[r].src;
            iack = tbl[r].iack;
            if (tbl[r].we) begin
                address = BASE + 16'(tbl[r].off);
                mem     = 1'b1;
                data    = 1'b1;
                read    = 1'b0;
                wdata   = tbl[r].wd;
            end else begin
                bus_idle();
            end
            tick();
            bus_idle();
            iack = 1'b0;
            exp_q.push_back(16'(tbl[r].exp_irq));
            exp_q.push_back(16'(tbl[r].exp_vec));
            exp_q.push_back(16'(tbl[r].exp_pend));
            exp_q.push_back(16'(tbl[r].exp_ins));
            #1;
            chk($sformatf("row%0d_irq", r), 16'(irq), exp_q.pop_front());
            chk($sformatf("row%0d_vec", r), 16'(int_vec), exp_q.pop_front());
            read_reg(BASE + 16'd2, v);
            chk($sformatf("row%0d_pending", r), v, exp_q.pop_front());
            read_reg(BASE + 16'd6, v);
            chk($sformatf("row%0d_inserv", r), v, exp_q.pop_front());
        end

        // ---------------- bus decode ----------------
        word = 1'b1;
        bus_write(BASE + 16'd1, 16'hFF5A);
        word = 1'b0;
        read_reg(BASE, v);
        chk("decode_enable_even", v, 16'h005A);
        read_reg(BASE + 16'd1, v);
        chk("decode_enable_odd", v, 16'h005A);
        read_reg(BASE + 16'd4, v);
        chk("decode_mode_read", v, 16'h0002);
        address = BASE + 16'd4; mem = 1'b0; data = 1'b1; read = 1'b1;
        #1;
        chk("decode_nomem_sel", 16'(sel), 16'h0000);
        chk("decode_nomem_rdata", rdata, 16'h0000);
        mem = 1'b1; data = 1'b0;
        #1;
        chk("decode_nodata_sel", 16'(sel), 16'h0000);
        address = BASE + 16'd8; data = 1'b1;
        #1;
        chk("decode_outside_sel", 16'(sel), 16'h0000);
        chk("decode_outside_rdata", rdata, 16'h0000);
        address = BASE + 16'd7;
        #1;
        chk("decode_inside_sel", 16'(sel), 16'h0001);
        bus_idle();

        // ---------------- held iack, then pre-emption ----------------
        src = 8'h08;
        tick();
        chk("held_pre_irq", 16'(irq), 16'h0001);
        chk("held_pre_vec", 16'(int_vec), 16'd19);
        iack = 1'b1;
        tick();
        chk("held_first_irq", 16'(irq), 16'h0000);
        tick();
        iack = 1'b0;
        read_reg(BASE + 16'd6, v);
        chk("held_inserv", v, 16'h0008);
        read_reg(BASE + 16'd2, v);
        chk("held_pending", v, 16'h0008);
        src = 8'h0A;
        tick();
        chk("preempt_irq", 16'(irq), 16'h0001);
        chk("preempt_vec", 16'(int_vec), 16'd17);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irq", 16'(irq), 16'h0000);
        chk("async_rst_vec", 16'(int_vec), 16'h0000);
        for (int k = 0; k < 4; k++) begin
            read_reg(BASE + 16'(2 * k), v);
            chk($sformatf("async_rst_reg%0d", 2 * k), v, 16'h0000);
        end
        src = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_irq", 16'(irq), 16'h0000);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
